// File: rtl/sap_microseq_if.sv
// Handshake/bus bundle between the SAP microsequencer and its IR/datapath/loader.
// Step-mode signals exist only when SAP_MICROSEQ_STEP_EN is defined.
interface sap_microseq_if #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned CW   = 12,
  parameter int unsigned TMAX = 6,
  parameter int unsigned CNTW = 8
);
  localparam int unsigned TW = $clog2(TMAX);

  logic              go;
  logic [OPW-1:0]    opcode;
  logic              cond;
  logic              uc_we;
  logic [OPW+TW-1:0] uc_addr;
  logic [CW+2:0]     uc_wdata;
`ifdef SAP_MICROSEQ_STEP_EN
  logic              step_mode;
  logic              step;
`endif
  logic [CW-1:0]     ctrl_out;
  logic [TW-1:0]     tstate;
  logic              running;
  logic              halted;
  logic [CNTW-1:0]   icount;

  modport master (
`ifdef SAP_MICROSEQ_STEP_EN
    output step_mode, output step,
`endif
    output go, output opcode, output cond,
    output uc_we, output uc_addr, output uc_wdata,
    input  ctrl_out, input tstate, input running, input halted, input icount
  );

  modport slave (
`ifdef SAP_MICROSEQ_STEP_EN
    input  step_mode, input step,
`endif
    input  go, input opcode, input cond,
    input  uc_we, input uc_addr, input uc_wdata,
    output ctrl_out, output tstate, output running, output halted, output icount
  );
endinterface

// File: rtl/sap_microseq.sv
// RAM-programmable SAP microsequencer: microword {HLT,END,CND,CTRL} per {opcode,tstate}.
// Optional single-step gating under SAP_MICROSEQ_STEP_EN.
module sap_microseq #(
  parameter int unsigned OPW  = 4,
  parameter int unsigned CW   = 12,
  parameter int unsigned TMAX = 6,
  parameter int unsigned CNTW = 8
) (
  input logic            clk_i,
  input logic            rst_ni,
  sap_microseq_if.slave  bus_io
);
  localparam int unsigned TW    = $clog2(TMAX);
  localparam int unsigned MW    = CW + 3;
  localparam int unsigned DEPTH = (2 ** OPW) * TMAX;
  localparam int unsigned IW    = $clog2(DEPTH);
  localparam int unsigned HLT_B = CW + 2;
  localparam int unsigned END_B = CW + 1;
  localparam int unsigned CND_B = CW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tstate_q, tstate_d;
  logic [CNTW-1:0] icount_q, icount_d;
  logic [CW-1:0]   ctrl_c;

  logic [MW-1:0]   ucode_q [DEPTH];
  logic [MW-1:0]   uword_c;
  logic [IW-1:0]   rd_idx_c, wr_idx_c;
  logic [OPW-1:0]  wr_op_c;
  logic [TW-1:0]   wr_t_c;
  logic            wr_ok_c, last_c, abort_c, adv_c;

  // Dense storage: row = opcode, column = tstate; out-of-range tstate writes dropped.
  assign {wr_op_c, wr_t_c} = bus_io.uc_addr;
  assign wr_ok_c  = (32'(wr_t_c) < TMAX);
  assign wr_idx_c = IW'(wr_op_c) * IW'(TMAX) + IW'(wr_t_c);
  assign rd_idx_c = IW'(bus_io.opcode) * IW'(TMAX) + IW'(tstate_q);
  assign uword_c  = ucode_q[rd_idx_c];

  // Microcode is deliberately not reset so a reload is not needed after rst.
  always_ff @(posedge clk_i) begin
    if (bus_io.uc_we && wr_ok_c) begin
      ucode_q[wr_idx_c] <= bus_io.uc_wdata;
    end
  end

  assign last_c  = (32'(tstate_q) == TMAX - 1);
  assign abort_c = uword_c[CND_B] && !bus_io.cond;

`ifdef SAP_MICROSEQ_STEP_EN
  assign adv_c = !bus_io.step_mode || bus_io.step;
`else
  assign adv_c = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      tstate_q <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      tstate_q <= tstate_d;
      icount_q <= icount_d;
    end
  end

  // Next state and control word; HLT outranks CND and END.
  always_comb begin
    state_d  = state_q;
    tstate_d = tstate_q;
    icount_d = icount_q;
    ctrl_c   = '0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus_io.go) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (adv_c) begin
          if (uword_c[HLT_B]) begin
            state_d  = S_HALT;
            tstate_d = '0;
            icount_d = icount_q + CNTW'(1);
          end else begin
            if (!abort_c) begin
              ctrl_c = uword_c[CW-1:0];
            end
            if (uword_c[END_B] || last_c || abort_c) begin
              tstate_d = '0;
              icount_d = icount_q + CNTW'(1);
            end else begin
              tstate_d = tstate_q + TW'(1);
            end
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        tstate_d = '0;
      end
    endcase
  end

  assign bus_io.ctrl_out = ctrl_c;
  assign bus_io.tstate   = tstate_q;
  assign bus_io.icount   = icount_q;
  assign bus_io.running  = (state_q == S_RUN);
  assign bus_io.halted   = (state_q == S_HALT);
endmodule

// File: tb/tb_sap_microseq.sv
// Randomized bench for sap_microseq against an instruction-level behavioural model,
// plus directed literal checks of the documented scenarios.
module tb_sap_microseq;
  localparam int unsigned OPW  = 4;
  localparam int unsigned CW   = 12;
  localparam int unsigned TMAX = 6;
  localparam int unsigned CNTW = 8;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam int unsigned MW   = CW + 3;
  localparam logic [MW-1:0] F_HLT = 15'h4000;
  localparam logic [MW-1:0] F_END = 15'h2000;
  localparam logic [MW-1:0] F_CND = 15'h1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sap_microseq_if #(.OPW(OPW), .CW(CW), .TMAX(TMAX), .CNTW(CNTW)) bus ();

  sap_microseq #(.OPW(OPW), .CW(CW), .TMAX(TMAX), .CNTW(CNTW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode flags, current step, retired count, microcode image.
  bit            m_run  = 1'b0;
  bit            m_halt = 1'b0;
  int            m_t    = 0;
  int            m_cnt  = 0;
  logic [MW-1:0] m_uc [16][TMAX];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit step_ok();
`ifdef SAP_MICROSEQ_STEP_EN
    return !bus.step_mode || bus.step;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_ctrl();
    logic [MW-1:0] w;
    if (!m_run || !step_ok()) return 32'h0;
    w = m_uc[bus.opcode][m_t];
    if (w[CW+2]) return 32'h0;
    if (w[CW] && !bus.cond) return 32'h0;
    return 32'(w[CW-1:0]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [MW-1:0] w;
    if (!rst_n) begin
      m_run = 1'b0; m_halt = 1'b0; m_t = 0; m_cnt = 0;
    end else if (m_run) begin
      w = m_uc[bus.opcode][m_t];
      if (step_ok()) begin
        if (w[CW+2]) begin
          m_run = 1'b0; m_halt = 1'b1; m_t = 0; m_cnt = m_cnt + 1;
        end else if (w[CW+1] || m_t == TMAX - 1 || (w[CW] && !bus.cond)) begin
          m_t = 0; m_cnt = m_cnt + 1;
        end else begin
          m_t = m_t + 1;
        end
      end
    end else if (bus.go) begin
      m_run = 1'b1; m_halt = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ctrl_out", 32'(bus.ctrl_out), model_ctrl());
    chk("tstate",   32'(bus.tstate),   32'(m_t));
    chk("running",  32'(bus.running),  32'(m_run));
    chk("halted",   32'(bus.halted),   32'(m_halt));
    chk("icount",   32'(bus.icount),   32'(m_cnt % (1 << CNTW)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic uc_write(input logic [OPW-1:0] op, input logic [TW-1:0] t, input logic [MW-1:0] d);
    bus.uc_we    = 1'b1;
    bus.uc_addr  = {op, t};
    bus.uc_wdata = d;
    tick();
    bus.uc_we = 1'b0;
    if (32'(t) < TMAX) m_uc[op][t] = d;
  endtask

  function automatic logic [MW-1:0] rand_word();
    logic [MW-1:0] w;
    w = MW'($urandom) & {3'b000, {CW{1'b1}}};
    if ($urandom_range(0, 15) == 0) w = w | F_HLT;
    if ($urandom_range(0, 3) == 0)  w = w | F_END;
    if ($urandom_range(0, 3) == 0)  w = w | F_CND;
    return w;
  endfunction

  initial begin
    logic [OPW-1:0] rop;
    logic [TW-1:0]  rt;
    logic [MW-1:0]  rd;
    bus.go = 1'b0; bus.opcode = '0; bus.cond = 1'b0;
    bus.uc_we = 1'b0; bus.uc_addr = '0; bus.uc_wdata = '0;
`ifdef SAP_MICROSEQ_STEP_EN
    bus.step_mode = 1'b0; bus.step = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(bus.ctrl_out), 32'h0);
    chk("rst_tstate", 32'(bus.tstate), 32'h0);
    chk("rst_icount", 32'(bus.icount), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int op = 0; op < 16; op++)
      for (int t = 0; t < int'(TMAX); t++) uc_write(OPW'(op), TW'(t), rand_word());
    uc_write(4'h0, 3'd0, 15'h0280);
    uc_write(4'h0, 3'd1, 15'h0014);
    uc_write(4'h0, 3'd2, F_END | 15'h0003);
    for (int t = 0; t < int'(TMAX); t++) uc_write(4'h1, TW'(t), 15'h0100 | MW'(t));
    uc_write(4'h2, 3'd0, 15'h0800);
    uc_write(4'h2, 3'd1, F_CND | 15'h00F0);
    uc_write(4'h2, 3'd2, F_END | 15'h000F);
    uc_write(4'hF, 3'd0, 15'h0400);
    uc_write(4'hF, 3'd1, 15'h0020);
    uc_write(4'hF, 3'd2, F_HLT | 15'h0FFF);
    uc_write(4'hF, 3'd6, F_HLT | 15'h0ABC);

    // Opcode 0: three-step instruction with END at T2
    bus.opcode = 4'h0; bus.go = 1'b1; #1;
    chk("idle_before_go", 32'(bus.running), 32'h0);
    tick(); bus.go = 1'b0; #1;
    chk("op0_t0_ctrl", 32'(bus.ctrl_out), 32'h280);
    chk("op0_t0_model", model_ctrl(), 32'h280);
    chk("op0_t0_run", 32'(bus.running), 32'h1);
    tick(); #1;
    chk("op0_t1_ctrl", 32'(bus.ctrl_out), 32'h014);
    chk("op0_t1_ts", 32'(bus.tstate), 32'h1);
    tick(); #1;
    chk("op0_t2_ctrl", 32'(bus.ctrl_out), 32'h003);
    chk("op0_t2_ts", 32'(bus.tstate), 32'h2);
    tick(); #1;
    chk("op0_end_ts", 32'(bus.tstate), 32'h0);
    chk("op0_end_icount", 32'(bus.icount), 32'h1);
    chk("op0_end_model_cnt", 32'(m_cnt), 32'h1);

    // Opcode 1: no END, wraps at TMAX-1
    bus.opcode = 4'h1; #1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int t = 0; t < int'(TMAX); t++) begin
        chk("op1_ctrl", 32'(bus.ctrl_out), 32'h100 | 32'(t));
        chk("op1_ts", 32'(bus.tstate), 32'(t));
        tick(); #1;
      end
      chk("op1_icount", 32'(bus.icount), 32'(2 + rep));
    end

    // Opcode 2: conditional abort at T1
    bus.opcode = 4'h2; bus.cond = 1'b0; #1;
    chk("op2_t0_ctrl", 32'(bus.ctrl_out), 32'h800);
    tick(); #1;
    chk("op2_abort_ctrl", 32'(bus.ctrl_out), 32'h0);
    chk("op2_abort_model", model_ctrl(), 32'h0);
    tick(); #1;
    chk("op2_abort_ts", 32'(bus.tstate), 32'h0);
    chk("op2_abort_icount", 32'(bus.icount), 32'h4);
    bus.cond = 1'b1;
    tick(); #1;
    chk("op2_cnd_ctrl", 32'(bus.ctrl_out), 32'h0F0);
    tick(); #1;
    chk("op2_t2_ctrl", 32'(bus.ctrl_out), 32'h00F);
    chk("op2_t2_ts", 32'(bus.tstate), 32'h2);
    tick(); #1;
    chk("op2_icount", 32'(bus.icount), 32'h5);

    // Opcode F: go ignored in RUN, HLT at T2, then restart
    bus.opcode = 4'hF; bus.go = 1'b1; #1;
    chk("opF_t0_ctrl", 32'(bus.ctrl_out), 32'h400);
    tick(); #1;
    chk("opF_go_ignored_ts", 32'(bus.tstate), 32'h1);
    chk("opF_t1_ctrl", 32'(bus.ctrl_out), 32'h020);
    bus.go = 1'b0;
    tick(); #1;
    chk("opF_hlt_ctrl", 32'(bus.ctrl_out), 32'h0);
    tick(); #1;
    chk("halt_halted", 32'(bus.halted), 32'h1);
    chk("halt_running", 32'(bus.running), 32'h0);
    chk("halt_ts", 32'(bus.tstate), 32'h0);
    chk("halt_icount", 32'(bus.icount), 32'h6);
    tick(); #1;
    chk("halt_hold", 32'(bus.halted), 32'h1);
    bus.go = 1'b1; bus.opcode = 4'h0;
    tick(); bus.go = 1'b0; #1;
    chk("resume_ctrl", 32'(bus.ctrl_out), 32'h280);
    chk("resume_run", 32'(bus.running), 32'h1);

    // Asynchronous reset mid-instruction, microcode retained
    tick(); #1;
    chk("pre_rst_ctrl", 32'(bus.ctrl_out), 32'h014);
    rst_n = 1'b0; #1;
    chk("async_rst_ctrl", 32'(bus.ctrl_out), 32'h0);
    chk("async_rst_ts", 32'(bus.tstate), 32'h0);
    chk("async_rst_icount", 32'(bus.icount), 32'h0);
    chk("async_rst_run", 32'(bus.running), 32'h0);
    tick(); rst_n = 1'b1;
    tick(); #1;
    chk("post_rst_idle", 32'(bus.running), 32'h0);
    bus.go = 1'b1;
    tick(); bus.go = 1'b0; #1;
    chk("retained_ctrl", 32'(bus.ctrl_out), 32'h280);

`ifdef SAP_MICROSEQ_STEP_EN
    // Step mode: advance only on every third cycle
    bus.opcode = 4'h1; bus.step_mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.step = (k % 3 == 2); #1;
      chk("step_ts", 32'(bus.tstate), 32'(k / 3));
      chk("step_ctrl", 32'(bus.ctrl_out), bus.step ? (32'h100 | 32'(k / 3)) : 32'h0);
      tick();
    end
    bus.step_mode = 1'b0; bus.step = 1'b0;
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      bus.cond = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) bus.opcode = OPW'($urandom);
      bus.go = ($urandom_range(0, 5) == 0);
`ifdef SAP_MICROSEQ_STEP_EN
      if ($urandom_range(0, 99) == 0) bus.step_mode = ~bus.step_mode;
      bus.step = 1'($urandom_range(0, 1));
`endif
      rop = OPW'($urandom);
      rt  = TW'($urandom);
      rd  = rand_word();
      bus.uc_we    = ($urandom_range(0, 15) == 0);
      bus.uc_addr  = {rop, rt};
      bus.uc_wdata = rd;
      tick();
      if (bus.uc_we && 32'(rt) < TMAX) m_uc[rop][rt] = rd;
      bus.uc_we = 1'b0;
    end
    bus.go = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
